// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit sitting behind the ALU of the RV32I core. It
// takes the effective address, rs2 data and memory controls, drives a
// word-wide data-memory bus with a req/ready handshake, and returns aligned,
// sign- or zero-extended load data for writeback. The single-cycle datapath
// is held with lsu_stall while an access is in flight.
//
// Ports:
//   pll_1_200MHz         core clock (rising edge)
//   pll_1_locked_synced  synchronous active-low reset
//   mem_read/mem_write   load/store request (both high = store)
//   funct3               access size and signedness
//   alu_result           effective byte address
//   store_data           rs2 value
//   lsu_stall            freeze PC / register-file write (combinational)
//   load_data/load_valid extended load result and its one-cycle pulse
//   lsu_fault/fault_cause one-cycle fault pulse and cause (01/10/11)
//   dmem_*               data-memory bus (registered request side)
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        pll_1_200MHz,
    input  logic        pll_1_locked_synced,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_fault,
    output logic [1:0]  fault_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_en,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Timeout fires on the last permitted BUSY cycle without ready, so the
    // request stays up for exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;

    logic        op;
    logic        f3_illegal;
    logic        misaligned;
    logic [31:0] wdata_next;
    logic [3:0]  byte_en_next;
    logic        timeout_hit;

    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] timeout_count;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // ------------------------------------------------------------------
    // Request decode from the IDLE-cycle inputs
    // ------------------------------------------------------------------
    always_comb begin
        op = mem_read | mem_write;

        // mem_write wins when both are set, so store legality applies
        if (mem_write) begin
            f3_illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            f3_illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end

        case (funct3[1:0])
            2'b01:   misaligned = alu_result[0];
            2'b10:   misaligned = (alu_result[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        wdata_next   = '0;
        byte_en_next = 4'b1111;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_next   = {4{store_data[7:0]}};
                    byte_en_next = 4'b0001 << alu_result[1:0];
                end
                2'b01: begin
                    wdata_next   = {2{store_data[15:0]}};
                    byte_en_next = alu_result[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_next   = store_data;
                    byte_en_next = 4'b1111;
                end
            endcase
        end

        timeout_hit = (timeout_count == TIMEOUT_LAST);
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension from the registered lane/funct3
    // ------------------------------------------------------------------
    always_comb begin
        case (lane_q)
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pll_1_200MHz) begin
        if (!pll_1_locked_synced) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and stall. Stall never looks at dmem_ready, which
    // keeps the bus out of the PC-enable timing path.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lsu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                lsu_stall = op;
                if (op) begin
                    state_d = (f3_illegal || misaligned) ? DONE : BUSY;
                end
            end
            BUSY: begin
                lsu_stall = 1'b1;
                if (dmem_ready || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and bus registers
    // ------------------------------------------------------------------
    always_ff @(posedge pll_1_200MHz) begin
        if (!pll_1_locked_synced) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_byte_en  <= '0;
            funct3_q      <= '0;
            lane_q        <= '0;
            timeout_count <= '0;
            load_data     <= '0;
            load_valid    <= 1'b0;
            lsu_fault     <= 1'b0;
            fault_cause   <= '0;
        end else begin
            load_valid <= 1'b0;
            lsu_fault  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op) begin
                        dmem_we       <= mem_write;
                        dmem_addr     <= {alu_result[31:2], 2'b00};
                        dmem_wdata    <= wdata_next;
                        dmem_byte_en  <= byte_en_next;
                        funct3_q      <= funct3;
                        lane_q        <= alu_result[1:0];
                        timeout_count <= '0;
                        // Illegal funct3 is reported ahead of misalignment
                        if (f3_illegal) begin
                            lsu_fault   <= 1'b1;
                            fault_cause <= 2'b10;
                            load_data   <= '0;
                        end else if (misaligned) begin
                            lsu_fault   <= 1'b1;
                            fault_cause <= 2'b01;
                            load_data   <= '0;
                        end else begin
                            dmem_req <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= load_ext;
                            load_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        dmem_req    <= 1'b0;
                        lsu_fault   <= 1'b1;
                        fault_cause <= 2'b11;
                        load_data   <= '0;
                    end else begin
                        timeout_count <= timeout_count + 16'd1;
                    end
                end
                DONE: begin
                    fault_cause   <= '0;
                    timeout_count <= '0;
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
